// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: instruction-cache geometry defaults and FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

   localparam int CPU_ADDR_W     = 16;
   localparam int CPU_LINE_WORDS = 8;
   localparam int CPU_LINES      = 32;
   localparam int CPU_OFS_W      = $clog2(CPU_LINE_WORDS);
   localparam int CPU_IDX_W      = $clog2(CPU_LINES);
   localparam int CPU_TAG_W      = CPU_ADDR_W - CPU_IDX_W - CPU_OFS_W;

   // Program-cache controller states
   typedef enum logic [1:0] {
      PC_LOOKUP = 2'd0,
      PC_REQ    = 2'd1,
      PC_FILL   = 2'd2,
      PC_RETRY  = 2'd3
   } pc_state_t;

endpackage

// File: rtl/cache_ram.sv
// Single-port RAM with one write port and a registered (synchronous) read.
// Latency: read data appears one cycle after the address; reads during a write return old data.
// Backpressure: none; a read and/or write is accepted every cycle.
module cache_ram #(
   parameter int DEPTH = 256,
   parameter int WIDTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [AW-1:0]    addr_i,
   input  logic             we_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // Storage write; contents deliberately survive reset
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   // Registered read port, cleared by reset so the output starts at zero
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/prog_cache.sv
// Direct-mapped read-only instruction cache; misses fill one line by SDRAM burst.
// Latency: hit returns instr one cycle after A; miss penalty 2 + ack wait + burst + 2 cycles.
// Backpressure: p_cache_miss stalls the PC, which replays A; mem_req is held until mem_ack.
module prog_cache
   import cpu_pkg::*;
#(
   parameter int LINE_WORDS = CPU_LINE_WORDS,
   parameter int LINES      = CPU_LINES
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CPU_ADDR_W-1:0] A,
   input  logic                  flush,
   output logic [CPU_ADDR_W-1:0] instr,
   output logic                  p_cache_miss,
   output logic                  mem_req,
   output logic [CPU_ADDR_W-1:0] mem_addr,
   input  logic                  mem_ack,
   input  logic                  mem_data_valid,
   input  logic [CPU_ADDR_W-1:0] mem_data
);

   localparam int OFS_W  = $clog2(LINE_WORDS);
   localparam int IDX_W  = $clog2(LINES);
   localparam int TAG_W  = CPU_ADDR_W - IDX_W - OFS_W;
   localparam int RAM_AW = IDX_W + OFS_W;
   localparam logic [OFS_W-1:0] LAST_OFS = OFS_W'(LINE_WORDS - 1);

   pc_state_t             state_q;
   logic [CPU_ADDR_W-1:0] a_q;
   logic [CPU_ADDR_W-1:0] miss_addr_q;
   logic [CPU_ADDR_W-1:0] mem_addr_q;
   logic                  lookup_v_q;
   logic                  mem_req_q;
   logic                  flush_pend_q;
   logic [OFS_W-1:0]      cnt_q;
   logic [LINES-1:0]      valid_q;

   logic [RAM_AW-1:0]     ram_addr_d;
   logic                  data_we;
   logic                  tag_we;
   logic [TAG_W-1:0]      tag_rd;
   logic [IDX_W-1:0]      a_idx;
   logic [TAG_W-1:0]      a_tag;
   logic [IDX_W-1:0]      miss_idx;
   logic                  hit;
   logic                  lookup_miss;

   assign a_idx    = a_q[OFS_W +: IDX_W];
   assign a_tag    = a_q[CPU_ADDR_W-1 -: TAG_W];
   assign miss_idx = miss_addr_q[OFS_W +: IDX_W];

   // The compare sees valid bits as they stand now, so a same-cycle flush only affects later lookups
   assign hit          = valid_q[a_idx] & (tag_rd == a_tag);
   assign lookup_miss  = lookup_v_q & ~hit;
   assign p_cache_miss = (state_q != PC_LOOKUP) | lookup_miss;

   assign data_we = (state_q == PC_FILL) & mem_data_valid;
   assign tag_we  = data_we & (cnt_q == LAST_OFS);

   // Array address: fetch address while looking up, fill slot during burst, replayed address on retry
   always_comb begin
      ram_addr_d = A[RAM_AW-1:0];
      case (state_q)
         PC_FILL:  ram_addr_d = {miss_idx, cnt_q};
         PC_RETRY: ram_addr_d = miss_addr_q[RAM_AW-1:0];
         default:  ram_addr_d = A[RAM_AW-1:0];
      endcase
   end

   cache_ram #(
      .DEPTH (LINES * LINE_WORDS),
      .WIDTH (CPU_ADDR_W)
   ) u_data_ram (
      .clk     (clk),
      .rst     (rst),
      .addr_i  (ram_addr_d),
      .we_i    (data_we),
      .wdata_i (mem_data),
      .rdata_o (instr)
   );

   cache_ram #(
      .DEPTH (LINES),
      .WIDTH (TAG_W)
   ) u_tag_ram (
      .clk     (clk),
      .rst     (rst),
      .addr_i  (ram_addr_d[RAM_AW-1:OFS_W]),
      .we_i    (tag_we),
      .wdata_i (miss_addr_q[CPU_ADDR_W-1 -: TAG_W]),
      .rdata_o (tag_rd)
   );

   // Miss controller: lookup, burst request, line fill, replay; flushes during a miss wait until after the replay hit
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= PC_LOOKUP;
         a_q          <= '0;
         miss_addr_q  <= '0;
         mem_addr_q   <= '0;
         lookup_v_q   <= 1'b0;
         mem_req_q    <= 1'b0;
         flush_pend_q <= 1'b0;
         cnt_q        <= '0;
         valid_q      <= '0;
      end else begin
         case (state_q)
            PC_LOOKUP: begin
               if (flush || flush_pend_q) begin
                  valid_q <= '0;
               end
               flush_pend_q <= 1'b0;
               if (lookup_miss) begin
                  miss_addr_q <= a_q;
                  mem_addr_q  <= {a_q[CPU_ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
                  mem_req_q   <= 1'b1;
                  lookup_v_q  <= 1'b0;
                  state_q     <= PC_REQ;
               end else begin
                  a_q        <= A;
                  lookup_v_q <= 1'b1;
               end
            end
            PC_REQ: begin
               if (flush) begin
                  flush_pend_q <= 1'b1;
               end
               if (mem_ack) begin
                  mem_req_q <= 1'b0;
                  cnt_q     <= '0;
                  state_q   <= PC_FILL;
               end
            end
            PC_FILL: begin
               if (flush) begin
                  flush_pend_q <= 1'b1;
               end
               if (mem_data_valid) begin
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == LAST_OFS) begin
                     valid_q[miss_idx] <= 1'b1;
                     state_q           <= PC_RETRY;
                  end
               end
            end
            default: begin
               if (flush) begin
                  flush_pend_q <= 1'b1;
               end
               a_q        <= miss_addr_q;
               lookup_v_q <= 1'b1;
               state_q    <= PC_LOOKUP;
            end
         endcase
      end
   end

   assign mem_req  = mem_req_q;
   assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_prog_cache.sv
// Directed bench for prog_cache: the bench acts as PC unit and SDRAM controller.
// Latency: inputs change 1 time unit after the rising edge, outputs are sampled there too.
// Backpressure: the bench holds A while p_cache_miss is high, as the PC unit does.
module tb_prog_cache;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] A;
   logic        flush;
   logic [15:0] instr;
   logic        p_cache_miss;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic        mem_data_valid;
   logic [15:0] mem_data;

   int errs   = 0;
   int checks = 0;

   prog_cache dut (
      .clk            (clk),
      .rst            (rst),
      .A              (A),
      .flush          (flush),
      .instr          (instr),
      .p_cache_miss   (p_cache_miss),
      .mem_req        (mem_req),
      .mem_addr       (mem_addr),
      .mem_ack        (mem_ack),
      .mem_data_valid (mem_data_valid),
      .mem_data       (mem_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Serve one line request: optional ack delay, gaps between words, flush pulse on the first word.
   // Ends in the replay-hit cycle and checks the word returned there.
   task automatic fill(input string nm, input logic [15:0] exp_addr, input logic [15:0] dbase,
                       input int ack_dly, input int gap, input bit fl, input logic [15:0] exp_instr);
      bit held   = 1'b1;
      bit stable = 1'b1;
      for (int t = 0; t < 16 && !mem_req; t++) tick();
      check({nm, "_req"}, mem_req, 1);
      check({nm, "_addr"}, mem_addr, exp_addr);
      for (int t = 0; t < ack_dly; t++) begin
         if (!mem_req || mem_addr !== exp_addr || !p_cache_miss) stable = 1'b0;
         tick();
      end
      mem_ack = 1'b1;
      if (!mem_req || mem_addr !== exp_addr) stable = 1'b0;
      tick();
      mem_ack = 1'b0;
      check({nm, "_req_stable"}, stable, 1);
      check({nm, "_req_drop"}, mem_req, 0);
      for (int i = 0; i < 8; i++) begin
         for (int g = 0; g < gap; g++) begin
            if (!p_cache_miss) held = 1'b0;
            tick();
         end
         if (!p_cache_miss) held = 1'b0;
         mem_data_valid = 1'b1;
         mem_data       = dbase + 16'(i);
         flush          = fl && (i == 0);
         tick();
         mem_data_valid = 1'b0;
         flush          = 1'b0;
         mem_data       = 16'hdead;
      end
      check({nm, "_miss_held"}, held, 1);
      check({nm, "_retry_miss"}, p_cache_miss, 1);
      tick();
      check({nm, "_hit_nomiss"}, p_cache_miss, 0);
      check({nm, "_hit_instr"}, instr, exp_instr);
   endtask

   logic [15:0] b2b_a [3];
   logic [15:0] b2b_e [3];

   initial begin
      b2b_a[0] = 16'h0001; b2b_e[0] = 16'h1001;
      b2b_a[1] = 16'h0007; b2b_e[1] = 16'h1007;
      b2b_a[2] = 16'h0003; b2b_e[2] = 16'h1003;

      rst = 1'b1; A = 16'h0000; flush = 1'b0;
      mem_ack = 1'b0; mem_data_valid = 1'b0; mem_data = 16'h0000;
      tick();
      tick();
      check("rst_miss", p_cache_miss, 0);
      check("rst_req", mem_req, 0);
      check("rst_addr", mem_addr, 16'h0000);
      check("rst_instr", instr, 16'h0000);

      // Cold miss on address 0
      rst = 1'b0;
      tick();
      check("cold_miss", p_cache_miss, 1);
      check("cold_req_late", mem_req, 0);
      tick();
      fill("cold", 16'h0000, 16'h1000, 1, 0, 1'b0, 16'h1000);

      // Back-to-back hits within line 0
      for (int i = 0; i < 3; i++) begin
         A = b2b_a[i];
         tick();
         check($sformatf("b2b%0d_instr", i), instr, b2b_e[i]);
         check($sformatf("b2b%0d_miss", i), p_cache_miss, 0);
      end

      // Conflict: tag 1 at index 0 evicts the resident line
      A = 16'h0100;
      tick();
      check("conf_miss", p_cache_miss, 1);
      tick();
      fill("conf", 16'h0100, 16'h2000, 0, 0, 1'b0, 16'h2000);
      A = 16'h0000;
      tick();
      check("evict_miss", p_cache_miss, 1);
      tick();
      // Slow ack and gapped burst
      fill("slow", 16'h0000, 16'h1000, 5, 2, 1'b0, 16'h1000);

      // Flush in LOOKUP: same-cycle lookup still hits, the next one misses
      A = 16'h0002;
      tick();
      check("pre_flush_instr", instr, 16'h1002);
      check("pre_flush_miss", p_cache_miss, 0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_miss", p_cache_miss, 1);
      fill("flush", 16'h0000, 16'h3000, 0, 0, 1'b0, 16'h3002);

      // Flush during FILL: one hit, then a re-access misses
      A = 16'h0040;
      tick();
      check("flfill_miss", p_cache_miss, 1);
      fill("flfill", 16'h0040, 16'h4000, 0, 1, 1'b1, 16'h4000);
      tick();
      check("flfill_remiss", p_cache_miss, 1);
      fill("flfill2", 16'h0040, 16'h4100, 0, 0, 1'b0, 16'h4100);
      A = 16'h0000;
      tick();
      check("flfill_line0_gone", p_cache_miss, 1);
      fill("line0", 16'h0000, 16'h3100, 0, 0, 1'b0, 16'h3100);

      // Reset in the middle of a burst
      A = 16'h0080;
      tick();
      check("rmf_miss", p_cache_miss, 1);
      tick();
      check("rmf_req", mem_req, 1);
      check("rmf_addr", mem_addr, 16'h0080);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         mem_data_valid = 1'b1;
         mem_data       = 16'h6000 + 16'(i);
         tick();
         mem_data_valid = 1'b0;
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rmf_rst_req", mem_req, 0);
      check("rmf_rst_miss", p_cache_miss, 0);
      check("rmf_rst_addr", mem_addr, 16'h0000);
      check("rmf_rst_instr", instr, 16'h0000);
      tick();
      check("rmf_remiss", p_cache_miss, 1);
      tick();
      fill("refill", 16'h0080, 16'h5000, 2, 1, 1'b0, 16'h5000);
      A = 16'h0082;
      tick();
      check("refill_w2", instr, 16'h5002);
      check("refill_w2_miss", p_cache_miss, 0);
      A = 16'h0087;
      tick();
      check("refill_w7", instr, 16'h5007);
      check("refill_w7_miss", p_cache_miss, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
